cache_req_arbiter: RTL and testbench

CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

---
 rtl/cache_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cache_req_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_arbiter.sv
// Two-port + flush request arbiter in front of a single-issue cache.
// Ports:
//   clk, reset          : clock, async active-low reset
//   pN_valid/ready      : request handshake, ready is combinational
//   pN_req_type/addr/.. : request fields (0=read, 1=write)
//   pN_done/pN_rdata    : completion pulse and held read data
//   flush_in/flush_ack  : flush level request and completion pulse
//   c_*                 : registered cache request side, c_src_ready
//                         acts as accept (ISSUE) and done (WAIT)
module cache_req_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_req_type,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_done,
    output logic [31:0] p0_rdata,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_req_type,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_done,
    output logic [31:0] p1_rdata,
    input  logic        flush_in,
    output logic        flush_ack,
    output logic        c_src_valid,
    input  logic        c_src_ready,
    output logic        c_cpu_req,
    output logic        c_flush_req,
    output logic        c_req_type,
    output logic [31:0] c_cpu_addr,
    output logic [31:0] c_cpu_wdata,
    input  logic [31:0] c_cpu_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {SRC_P0, SRC_P1, SRC_FL} src_t;

    state_t      state_q;
    src_t        src_q;
    logic        last_q;
    logic        valid_q;
    logic        cpu_req_q;
    logic        flush_req_q;
    logic        type_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;
    logic        done0_q;
    logic        done1_q;
    logic        fack_q;

    logic        idle_d;
    logic        fl_gnt_d;
    logic        p0_gnt_d;
    logic        p1_gnt_d;

    // flush_in is still high in the cycle its ack is presented, so it is
    // masked then to avoid granting the same flush twice.
    assign idle_d   = (state_q == IDLE);
    assign fl_gnt_d = idle_d & flush_in & ~fack_q;
    // last_q=1 means p1 was granted last, so p0 wins a tie.
    assign p0_gnt_d = idle_d & ~fl_gnt_d & p0_valid & (~p1_valid | last_q);
    assign p1_gnt_d = idle_d & ~fl_gnt_d & p1_valid & (~p0_valid | ~last_q);

    assign p0_ready    = p0_gnt_d;
    assign p1_ready    = p1_gnt_d;
    assign p0_done     = done0_q;
    assign p1_done     = done1_q;
    assign flush_ack   = fack_q;
    assign p0_rdata    = rdata0_q;
    assign p1_rdata    = rdata1_q;
    assign c_src_valid = valid_q;
    assign c_cpu_req   = cpu_req_q;
    assign c_flush_req = flush_req_q;
    assign c_req_type  = type_q;
    assign c_cpu_addr  = addr_q;
    assign c_cpu_wdata = wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            src_q       <= SRC_P0;
            last_q      <= 1'b1;
            valid_q     <= 1'b0;
            cpu_req_q   <= 1'b0;
            flush_req_q <= 1'b0;
            type_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            fack_q      <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            fack_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (fl_gnt_d) begin
                        src_q       <= SRC_FL;
                        valid_q     <= 1'b1;
                        flush_req_q <= 1'b1;
                        state_q     <= ISSUE;
                    end else if (p0_gnt_d) begin
                        src_q     <= SRC_P0;
                        last_q    <= 1'b0;
                        type_q    <= p0_req_type;
                        addr_q    <= p0_addr;
                        wdata_q   <= p0_wdata;
                        valid_q   <= 1'b1;
                        cpu_req_q <= 1'b1;
                        state_q   <= ISSUE;
                    end else if (p1_gnt_d) begin
                        src_q     <= SRC_P1;
                        last_q    <= 1'b1;
                        type_q    <= p1_req_type;
                        addr_q    <= p1_addr;
                        wdata_q   <= p1_wdata;
                        valid_q   <= 1'b1;
                        cpu_req_q <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (valid_q && c_src_ready) begin
                        valid_q     <= 1'b0;
                        cpu_req_q   <= 1'b0;
                        flush_req_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (c_src_ready) begin
                        state_q <= IDLE;
                        unique case (src_q)
                            SRC_P0: begin
                                done0_q <= 1'b1;
                                if (!type_q) rdata0_q <= c_cpu_rdata;
                            end
                            SRC_P1: begin
                                done1_q <= 1'b1;
                                if (!type_q) rdata1_q <= c_cpu_rdata;
                            end
                            default: fack_q <= 1'b1;
                        endcase
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Scoreboard bench for cache_req_arbiter with a requester agent,
// a cache responder and a transaction-level arbitration model.
module tb_cache_req_arbiter;

    typedef struct {
        int          src;
        bit          typ;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          src;
        logic [31:0] rdata;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_valid, p0_ready, p0_req_type, p0_done;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_valid, p1_ready, p1_req_type, p1_done;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        flush_in, flush_ack;
    logic        c_src_valid, c_src_ready, c_cpu_req, c_flush_req;
    logic        c_req_type;
    logic [31:0] c_cpu_addr, c_cpu_wdata, c_cpu_rdata;

    always #5 clk = ~clk;

    cache_req_arbiter dut (
        .clk(clk), .reset(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready),
        .p0_req_type(p0_req_type), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready),
        .p1_req_type(p1_req_type), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .flush_in(flush_in), .flush_ack(flush_ack),
        .c_src_valid(c_src_valid), .c_src_ready(c_src_ready),
        .c_cpu_req(c_cpu_req), .c_flush_req(c_flush_req),
        .c_req_type(c_req_type), .c_cpu_addr(c_cpu_addr),
        .c_cpu_wdata(c_cpu_wdata), .c_cpu_rdata(c_cpu_rdata)
    );

    int    tests;
    int    fails;
    req_t  aq0[$];
    req_t  aq1[$];
    req_t  aqf[$];
    req_t  exp_iss[$];
    done_t exp_done[$];

    int          m_lg;
    bit          m_type;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rd[2];
    bit          ovr_en;
    logic [31:0] ovr_data;
    int          fix_stall, fix_lat;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] cache_word(logic [31:0] a);
        if (ovr_en) return ovr_data;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic void model_reset();
        m_lg = 1; m_type = 0; m_addr = 0; m_wdata = 0;
        m_rd[0] = 0; m_rd[1] = 0;
    endfunction

    // One served request in model order: latched fields, then response.
    function automatic void expect_req(req_t r);
        req_t  e;
        done_t d;
        if (r.src != 2) begin
            m_type = r.typ; m_addr = r.addr; m_wdata = r.wdata;
            m_lg = r.src;
            if (!r.typ) m_rd[r.src] = cache_word(r.addr);
        end
        e.src = r.src; e.typ = m_type; e.addr = m_addr; e.wdata = m_wdata;
        exp_iss.push_back(e);
        d.src = r.src;
        d.rdata = (r.src == 2) ? 32'h0 : m_rd[r.src];
        exp_done.push_back(d);
    endfunction

    // Requests raised together: flush first, then the port not served last.
    function automatic void plan_round(bit u0, bit u1, bit uf,
                                       req_t r0, req_t r1, req_t rf);
        if (u0) aq0.push_back(r0);
        if (u1) aq1.push_back(r1);
        if (uf) aqf.push_back(rf);
        if (uf) expect_req(rf);
        if (u0 && u1) begin
            if (m_lg == 1) begin expect_req(r0); expect_req(r1); end
            else begin expect_req(r1); expect_req(r0); end
        end else if (u0) expect_req(r0);
        else if (u1) expect_req(r1);
    endfunction

    function automatic req_t mk(int src, bit typ, logic [31:0] a,
                                logic [31:0] w);
        req_t r;
        r.src = src; r.typ = typ; r.addr = a; r.wdata = w;
        return r;
    endfunction

    // Requester agent: drops a request after its handshake, raises queued ones.
    initial begin
        req_t r;
        bit a0, a1, af;
        p0_valid = 0; p0_req_type = 0; p0_addr = 0; p0_wdata = 0;
        p1_valid = 0; p1_req_type = 0; p1_addr = 0; p1_wdata = 0;
        flush_in = 0;
        forever begin
            @(negedge clk);
            a0 = rst_n && p0_valid && p0_ready;
            a1 = rst_n && p1_valid && p1_ready;
            af = rst_n && flush_in && flush_ack;
            @(posedge clk);
            #1;
            if (a0) p0_valid = 0;
            if (a1) p1_valid = 0;
            if (af) flush_in = 0;
            if (!p0_valid && aq0.size() > 0) begin
                r = aq0.pop_front();
                p0_valid = 1; p0_req_type = r.typ;
                p0_addr = r.addr; p0_wdata = r.wdata;
            end
            if (!p1_valid && aq1.size() > 0) begin
                r = aq1.pop_front();
                p1_valid = 1; p1_req_type = r.typ;
                p1_addr = r.addr; p1_wdata = r.wdata;
            end
            if (!flush_in && aqf.size() > 0) begin
                r = aqf.pop_front();
                flush_in = 1;
            end
        end
    end

    // Cache responder: stall, accept, latency, completion with data.
    initial begin
        int st, lt;
        logic [31:0] a;
        c_src_ready = 0;
        c_cpu_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst_n && c_src_valid) begin
                st = (fix_stall < 0) ? $urandom_range(0, 3) : fix_stall;
                lt = (fix_lat < 0) ? $urandom_range(1, 5) : fix_lat;
                repeat (st) @(negedge clk);
                a = c_cpu_addr;
                @(posedge clk); #1 c_src_ready = 1;
                @(posedge clk); #1 c_src_ready = 0;
                repeat (lt) @(posedge clk);
                #1;
                c_src_ready = 1;
                c_cpu_rdata = cache_word(a);
                @(posedge clk); #1;
                c_src_ready = 0;
                c_cpu_rdata = $urandom();
            end
        end
    end

    // Monitor: checks issues and completions against the scoreboard.
    initial begin
        req_t  e;
        done_t d;
        bit pv, pt;
        logic [31:0] pa, pw;
        int src;
        pv = 0; pt = 0; pa = 0; pw = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0;
                continue;
            end
            if (p0_ready || p1_ready)
                chk("ready_onehot", p0_ready & p1_ready, 0);
            if (c_src_valid) begin
                chk("cpu_xor_flush", c_cpu_req ^ c_flush_req, 1);
                if (pv) begin
                    chk("stable_type", c_req_type, pt);
                    chk("stable_addr", c_cpu_addr, pa);
                    chk("stable_wdata", c_cpu_wdata, pw);
                end
                pv = 1; pt = c_req_type; pa = c_cpu_addr; pw = c_cpu_wdata;
            end else begin
                pv = 0;
            end
            if (c_src_valid && c_src_ready) begin
                if (exp_iss.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL issue_unexpected: got issue, expected none");
                end else begin
                    e = exp_iss.pop_front();
                    chk("iss_cpu_req", c_cpu_req, e.src != 2);
                    chk("iss_flush_req", c_flush_req, e.src == 2);
                    chk("iss_type", c_req_type, e.typ);
                    chk("iss_addr", c_cpu_addr, e.addr);
                    chk("iss_wdata", c_cpu_wdata, e.wdata);
                end
            end
            if (p0_done || p1_done || flush_ack) begin
                chk("done_onehot",
                    int'(p0_done) + int'(p1_done) + int'(flush_ack), 1);
                src = p1_done ? 1 : (flush_ack ? 2 : 0);
                if (exp_done.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL done_unexpected: got src %0d, expected none",
                             src);
                end else begin
                    d = exp_done.pop_front();
                    chk("done_src", src, d.src);
                    if (d.src == 0) chk("p0_rdata", p0_rdata, d.rdata);
                    if (d.src == 1) chk("p1_rdata", p1_rdata, d.rdata);
                end
            end
        end
    end

    task automatic drain(string name);
        int n = 0;
        while ((exp_done.size() > 0 || exp_iss.size() > 0 ||
                aq0.size() > 0 || aq1.size() > 0 || aqf.size() > 0 ||
                p0_valid || p1_valid || flush_in) && n < 600) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 600) begin
            fails++;
            $display("FAIL %s timeout: got %0d pending, expected 0",
                     name, exp_done.size());
            exp_done.delete();
            exp_iss.delete();
        end
        @(posedge clk); #3;
    endtask

    task automatic wait_accept(string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(c_src_valid && c_src_ready) && n < 100);
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL %s accept timeout: got none, expected accept", name);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_valid"}, c_src_valid, 0);
        chk({tag, "_cpu_req"}, c_cpu_req, 0);
        chk({tag, "_flush_req"}, c_flush_req, 0);
        chk({tag, "_type"}, c_req_type, 0);
        chk({tag, "_addr"}, c_cpu_addr, 0);
        chk({tag, "_wdata"}, c_cpu_wdata, 0);
        chk({tag, "_p0_rdata"}, p0_rdata, 0);
        chk({tag, "_p1_rdata"}, p1_rdata, 0);
        chk({tag, "_dones"}, {p0_done, p1_done, flush_ack}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r0, r1, rf, rb;
        int n;
        tests = 0; fails = 0;
        fix_stall = 0; fix_lat = 3; ovr_en = 0; ovr_data = 0;
        model_reset();
        rf = mk(2, 0, 0, 0);
        rst_n = 0;
        #22;
        chk_reset_outputs("rst");

        // single read, granted on the first edge after reset release
        ovr_en = 1; ovr_data = 32'hDEAD_BEEF;
        r0 = mk(0, 0, 32'h0000_0040, 32'h0);
        plan_round(1, 0, 0, r0, r1, rf);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("rd_p0_ready", p0_ready, 1);
        chk("rd_p1_ready", p1_ready, 0);
        @(negedge clk);
        chk("rd_valid", c_src_valid, 1);
        chk("rd_addr", c_cpu_addr, 32'h40);
        chk("rd_ready_1cyc", p0_ready, 0);
        drain("single_read");
        ovr_en = 0;

        // simultaneous pairs after a fresh reset alternate from p0
        #2 rst_n = 0;
        @(posedge clk); #2 rst_n = 1;
        model_reset();
        @(posedge clk); #3;
        r0 = mk(0, 0, 32'h100, 0);
        r1 = mk(1, 0, 32'h200, 0);
        plan_round(1, 1, 0, r0, r1, rf);
        drain("pair1");
        r0 = mk(0, 1, 32'h104, 32'hA0A0_0001);
        r1 = mk(1, 0, 32'h204, 0);
        plan_round(1, 1, 0, r0, r1, rf);
        drain("pair2");

        // flush arrives during a p1 write in WAIT with p0 pending
        fix_lat = 5;
        r1 = mk(1, 1, 32'h80, 32'h1234_5678);
        plan_round(0, 1, 0, r0, r1, rf);
        wait_accept("p1_write");
        r0 = mk(0, 0, 32'h300, 0);
        aqf.push_back(rf);
        aq0.push_back(r0);
        expect_req(rf);
        expect_req(r0);
        drain("flush_prio");

        // ten-cycle stall in ISSUE
        fix_stall = 10; fix_lat = 2;
        r0 = mk(0, 0, 32'h444, 0);
        plan_round(1, 0, 0, r0, r1, rf);
        n = 0;
        while (!c_src_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", c_src_valid, 1);
            chk("stall_addr", c_cpu_addr, 32'h444);
            chk("stall_nodone", {p0_done, p1_done, flush_ack}, 0);
        end
        drain("stall");

        // reset in WAIT drops the request; pending p0 wins the first edge
        fix_stall = 0; fix_lat = 6;
        r0 = mk(0, 0, 32'h500, 0);
        plan_round(1, 0, 0, r0, r1, rf);
        wait_accept("pre_reset");
        rb = mk(0, 0, 32'h600, 0);
        aq0.push_back(rb);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk_reset_outputs("midrst");
        void'(exp_done.pop_front());
        model_reset();
        expect_req(rb);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rst_nodone", {p0_done, p1_done, flush_ack}, 0);
        end
        @(posedge clk); #2 rst_n = 1;
        @(negedge clk);
        chk("rel_p0_ready", p0_ready, 1);
        @(negedge clk);
        chk("rel_valid", c_src_valid, 1);
        chk("rel_addr", c_cpu_addr, 32'h600);
        drain("reset_wait");

        // randomized rounds
        fix_stall = -1; fix_lat = -1;
        for (int k = 0; k < 120; k++) begin
            int m;
            m = $urandom_range(1, 7);
            r0 = mk(0, 1'($urandom_range(0, 1)),
                    $urandom() & 32'hFFFF_FFFC, $urandom());
            r1 = mk(1, 1'($urandom_range(0, 1)),
                    $urandom() & 32'hFFFF_FFFC, $urandom());
            plan_round(m[0], m[1], m[2], r0, r1, rf);
            drain("random");
        end

        chk("sb_empty", exp_iss.size() + exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
